// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM states, requester count
// and the rotating-priority search used to pick the next owner.
// Pure declarations; no logic of its own.
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Returns {found, idx}: the first set request found when walking
  // ptr, ptr+1, ... modulo NUM_REQ. Walking the offsets from the far end
  // lets the nearest hit overwrite any farther one.
  function automatic logic [2:0] rr_search(input logic [NUM_REQ-1:0] req,
                                           input logic [1:0]         ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/decoder_2x4_df.sv
// 2-to-4 enable decoder, dataflow style: {a,b} selects one of q0..q3 when e=1.
// Latency: purely combinational.
// No flow control; all outputs low while e=0.
module decoder_2x4_df (
  input  logic a,
  input  logic b,
  input  logic e,
  output logic q0,
  output logic q1,
  output logic q2,
  output logic q3
);

  assign q0 = e & ~a & ~b;
  assign q1 = e & ~a &  b;
  assign q2 = e &  a & ~b;
  assign q3 = e &  a &  b;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with optional hold limit forcing rotation.
// Latency: grant visible one cycle after a request is sampled in IDLE.
// Non-owner requests wait; an owner is revoked after MAX_HOLD cycles (0 = never).
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [1:0]         gnt_idx,
  output logic               timeout
);

  arb_state_t       state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timeout_nxt;
  logic [2:0]       search;
  logic             hold_hit;

  // Owner exists exactly while in GRANT, so validity comes straight from state.
  assign gnt_valid = (state == ARB_GRANT);

  assign search   = rr_search(req, ptr);
  assign hold_hit = (MAX_HOLD != 0) && (cnt == CNT_W'(MAX_HOLD));

  // State register plus pointer, owner index, hold counter and timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      ptr     <= 2'd0;
      gnt_idx <= 2'd0;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt_idx <= idx_nxt;
      cnt     <= cnt_nxt;
      timeout <= timeout_nxt;
    end
  end

  // Next-state logic: release beats revoke, and ptr only moves when leaving GRANT.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    idx_nxt     = gnt_idx;
    cnt_nxt     = cnt;
    timeout_nxt = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (search[2]) begin
          idx_nxt   = search[1:0];
          cnt_nxt   = CNT_W'(1);
          state_nxt = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (!req[gnt_idx]) begin
          state_nxt = ARB_IDLE;
          ptr_nxt   = gnt_idx + 2'd1;
        end else if (hold_hit) begin
          state_nxt   = ARB_IDLE;
          ptr_nxt     = gnt_idx + 2'd1;
          timeout_nxt = 1'b1;
        end else if (cnt != {CNT_W{1'b1}}) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Grant decode is driven only from registers, so req glitches never reach gnt.
  decoder_2x4_df u_dec (
    .a  (gnt_idx[1]),
    .b  (gnt_idx[0]),
    .e  (gnt_valid),
    .q0 (gnt[0]),
    .q1 (gnt[1]),
    .q2 (gnt[2]),
    .q3 (gnt[3])
  );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: one instance unlimited hold, one with MAX_HOLD=3,
// each tracked by a behavioural owner/pointer model.
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst0_n, rst3_n;
  logic [3:0] req0, req3;
  logic [3:0] g0, g3;
  logic       v0, v3, t0, t3;
  logic [1:0] i0, i3;

  int passed = 0;
  int total  = 0;

  // Model: owner (-1 = none), priority start, hold count, last owner, pulse.
  int m_own[2], m_ptr[2], m_cnt[2], m_last[2];
  bit m_to[2];
  int m_max[2] = '{0, 3};

  always #5 clk = ~clk;

  rr_arbiter_4 #(.MAX_HOLD(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst0_n), .req(req0), .gnt(g0),
    .gnt_valid(v0), .gnt_idx(i0), .timeout(t0));

  rr_arbiter_4 #(.MAX_HOLD(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst_n(rst3_n), .req(req3), .gnt(g3),
    .gnt_valid(v3), .gnt_idx(i3), .timeout(t3));

  task automatic model_reset(int k);
    m_own[k] = -1; m_ptr[k] = 0; m_cnt[k] = 0; m_last[k] = 0; m_to[k] = 0;
  endtask

  task automatic model_edge(int k);
    logic [3:0] r;
    logic       rn;
    r  = (k == 0) ? req0 : req3;
    rn = (k == 0) ? rst0_n : rst3_n;
    if (!rn) begin
      model_reset(k);
      return;
    end
    m_to[k] = 0;
    if (m_own[k] < 0) begin
      for (int i = 0; i < 4; i++) begin
        int c;
        c = (m_ptr[k] + i) % 4;
        if (r[c]) begin
          m_own[k] = c; m_last[k] = c; m_cnt[k] = 1;
          break;
        end
      end
    end else if (!r[m_own[k]]) begin
      m_ptr[k] = (m_own[k] + 1) % 4;
      m_own[k] = -1;
    end else if (m_max[k] != 0 && m_cnt[k] == m_max[k]) begin
      m_ptr[k] = (m_own[k] + 1) % 4;
      m_own[k] = -1;
      m_to[k]  = 1;
    end else if (m_cnt[k] < 15) begin
      m_cnt[k]++;
    end
  endtask

  function automatic logic [3:0] m_gnt(int k);
    logic [3:0] one;
    one = 4'b0001;
    return (m_own[k] < 0) ? 4'b0000 : (one << m_own[k]);
  endfunction

  // One clock: model updates on the edge, outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst0_n = 1'b0; rst3_n = 1'b0;
    req0 = 4'b1111; req3 = 4'b0000;
    model_reset(0); model_reset(1);
    repeat (3) step();
    total++; if (g0 !== 4'b0000) $display("FAIL reset_gnt got %b want 0000", g0); else passed++;
    total++; if (v0 !== 1'b0) $display("FAIL reset_valid got %b want 0", v0); else passed++;
    total++; if (t0 !== 1'b0) $display("FAIL reset_timeout got %b want 0", t0); else passed++;
    total++; if (i0 !== 2'd0) $display("FAIL reset_idx got %0d want 0", i0); else passed++;
    rst0_n = 1'b1;
    step();
    total++; if (g0 !== 4'b0001) $display("FAIL reset_first_gnt got %b want 0001", g0); else passed++;
  endtask

  task automatic test_rotation();
    logic [3:0] rot[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      total++; if (g0 !== rot[i]) $display("FAIL rot_c1[%0d] got %b want %b", i, g0, rot[i]); else passed++;
      step();
      total++; if (g0 !== rot[i]) $display("FAIL rot_c2[%0d] got %b want %b", i, g0, rot[i]); else passed++;
      req0 = 4'b1111 & ~rot[i];
      step();
      total++; if (g0 !== 4'b0000 || v0 !== 1'b0)
        $display("FAIL rot_idle[%0d] got gnt=%b v=%b want 0000/0", i, g0, v0); else passed++;
      total++; if (i0 !== 2'(m_last[0])) $display("FAIL rot_idx_hold[%0d] got %0d want %0d", i, i0, m_last[0]); else passed++;
      req0 = 4'b1111;
      step();
    end
  endtask

  task automatic test_pointer_search();
    // dut0 currently owned by requester 1; its release moves priority to 2.
    req0 = 4'b0001;
    step();
    total++; if (g0 !== 4'b0000) $display("FAIL ptr_idle got %b want 0000", g0); else passed++;
    req0 = 4'b0011;
    step();
    total++; if (g0 !== 4'b0001) $display("FAIL ptr_search got %b want 0001", g0); else passed++;
    total++; if (g0 !== m_gnt(0)) $display("FAIL ptr_model got %b want %b", g0, m_gnt(0)); else passed++;
    req0 = 4'b0000;
    repeat (2) step();
  endtask

  task automatic test_timeout();
    logic [3:0] pat[8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000,
                           4'b0100, 4'b0100, 4'b0100, 4'b0000};
    logic       tpat[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    rst3_n = 1'b1;
    req3   = 4'b0101;
    for (int c = 0; c < 16; c++) begin
      step();
      total++; if (g3 !== pat[c % 8]) $display("FAIL to_gnt[%0d] got %b want %b", c, g3, pat[c % 8]); else passed++;
      total++; if (t3 !== tpat[c % 8]) $display("FAIL to_pulse[%0d] got %b want %b", c, t3, tpat[c % 8]); else passed++;
    end
    req3 = 4'b0000;
    repeat (2) step();
  endtask

  task automatic test_release_timeout();
    rst3_n = 1'b0;
    step();
    rst3_n = 1'b1;
    req3   = 4'b0001;
    repeat (3) step();
    total++; if (g3 !== 4'b0001) $display("FAIL rt_third got %b want 0001", g3); else passed++;
    req3 = 4'b0000;
    step();
    total++; if (t3 !== 1'b0) $display("FAIL rt_timeout got %b want 0", t3); else passed++;
    total++; if (g3 !== 4'b0000) $display("FAIL rt_idle got %b want 0000", g3); else passed++;
    req3 = 4'b0011;
    step();
    total++; if (g3 !== 4'b0010) $display("FAIL rt_ptr_adv got %b want 0010", g3); else passed++;
    req3 = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid_grant();
    rst3_n = 1'b0;
    step();
    rst3_n = 1'b1;
    req3   = 4'b0010;
    step();
    req3 = 4'b0000;
    step();
    req3 = 4'b0100;
    step();
    total++; if (g3 !== 4'b0100) $display("FAIL mid_pre got %b want 0100", g3); else passed++;
    #2 rst3_n = 1'b0;
    model_reset(1);
    #1;
    total++; if (g3 !== 4'b0000 || v3 !== 1'b0)
      $display("FAIL mid_async got gnt=%b v=%b want 0000/0", g3, v3); else passed++;
    @(negedge clk);
    rst3_n = 1'b1;
    step();
    total++; if (g3 !== 4'b0100) $display("FAIL mid_regrant got %b want 0100", g3); else passed++;
    // With ptr back at 0, requester 1 outranks requester 2.
    req3 = 4'b0000;
    rst3_n = 1'b0;
    step();
    rst3_n = 1'b1;
    req3   = 4'b0110;
    step();
    total++; if (g3 !== 4'b0010) $display("FAIL mid_ptr0 got %b want 0010", g3); else passed++;
  endtask

  task automatic test_random();
    rst0_n = 1'b0; rst3_n = 1'b0;
    req0 = 4'b0000; req3 = 4'b0000;
    step();
    rst0_n = 1'b1; rst3_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) req0 = 4'($urandom);
      if ($urandom_range(3) == 0) req3 = 4'($urandom);
      step();
      total++; if (g0 !== m_gnt(0)) $display("FAIL rnd0_gnt[%0d] got %b want %b", n, g0, m_gnt(0)); else passed++;
      total++; if (i0 !== 2'(m_last[0])) $display("FAIL rnd0_idx[%0d] got %0d want %0d", n, i0, m_last[0]); else passed++;
      total++; if (t0 !== m_to[0]) $display("FAIL rnd0_to[%0d] got %b want %b", n, t0, m_to[0]); else passed++;
      total++; if (g3 !== m_gnt(1)) $display("FAIL rnd3_gnt[%0d] got %b want %b", n, g3, m_gnt(1)); else passed++;
      total++; if (v3 !== (m_own[1] >= 0)) $display("FAIL rnd3_valid[%0d] got %b want %b", n, v3, m_own[1] >= 0); else passed++;
      total++; if (i3 !== 2'(m_last[1])) $display("FAIL rnd3_idx[%0d] got %0d want %0d", n, i3, m_last[1]); else passed++;
      total++; if (t3 !== m_to[1]) $display("FAIL rnd3_to[%0d] got %b want %b", n, t3, m_to[1]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_pointer_search();
    test_timeout();
    test_release_timeout();
    test_reset_mid_grant();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
